// File: rtl/mod_exp_controller_pkg.sv
// Shared types and constants for the square-and-multiply
// modular exponentiation controller.
package mod_exp_controller_pkg;

  localparam int SIZE_DEF     = 64;
  localparam int EXP_BITS_DEF = 64;
  localparam int ACC_INIT     = 1;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    WAIT,
    RECYCLE,
    ADVANCE,
    DONE
  } state_e;

  typedef enum logic {
    PH_SQ,
    PH_MUL
  } phase_e;

endpackage

// File: rtl/mod_exp_controller_msb_finder.sv
// Priority encoder: index of the most significant set bit
// of the exponent, plus an all-zero flag.
module mod_exp_controller_msb_finder #(
  parameter  int EXP_BITS = 64,
  localparam int IW       = $clog2(EXP_BITS)
) (
  input  logic [EXP_BITS-1:0] exp_i,
  output logic [IW-1:0]       idx_o,
  output logic                zero_o
);

  always_comb begin
    idx_o  = '0;
    zero_o = 1'b1;
    for (int i = 0; i < EXP_BITS; i++) begin
      if (exp_i[i]) begin
        idx_o  = IW'(i);
        zero_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mod_exp_controller.sv
// Left-to-right square-and-multiply sequencer around one single-shot
// multiply-modulo unit. MODEXP_SKIP_LEADING_ZEROS_EN skips leading zero bits.
module mod_exp_controller
  import mod_exp_controller_pkg::*;
#(
  parameter  int SIZE     = SIZE_DEF,
  parameter  int EXP_BITS = EXP_BITS_DEF,
  localparam int IW       = $clog2(EXP_BITS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SIZE-1:0]     in_base_tdata,
  input  logic [EXP_BITS-1:0] in_exp_tdata,
  input  logic [SIZE-1:0]     in_mod_tdata,
  input  logic                in_tvalid,
  output logic                in_tready,
  output logic [SIZE-1:0]     out_tdata,
  output logic                out_err,
  output logic                out_tvalid,
  input  logic                out_tready,
  output logic                mm_rst,
  output logic [SIZE-1:0]     mm_multiplier_tdata,
  output logic [SIZE-1:0]     mm_multiplicand_tdata,
  output logic [SIZE-1:0]     mm_modulus_tdata,
  output logic                mm_in_tvalid,
  input  logic                mm_in_tready,
  input  logic [SIZE-1:0]     mm_out_tdata,
  input  logic                mm_out_tvalid,
  output logic                mm_out_tready,
  output logic                busy
);

  state_e              state_q, state_d;
  phase_e              phase_q, phase_d;
  logic [SIZE-1:0]     acc_q, acc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [SIZE-1:0]     base_q, base_d;
  logic [EXP_BITS-1:0] exp_q, exp_d;
  logic [SIZE-1:0]     mod_q, mod_d;
  logic [SIZE-1:0]     res_q, res_d;
  logic                err_q, err_d;

`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
  logic [IW-1:0] msb_idx;
  logic          msb_zero;

  mod_exp_controller_msb_finder #(
    .EXP_BITS(EXP_BITS)
  ) u_msb (
    .exp_i (exp_q),
    .idx_o (msb_idx),
    .zero_o(msb_zero)
  );
`endif

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    base_d  = base_q;
    exp_d   = exp_q;
    mod_d   = mod_q;
    res_d   = res_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_tvalid) begin
          base_d  = in_base_tdata;
          exp_d   = in_exp_tdata;
          mod_d   = in_mod_tdata;
          acc_d   = SIZE'(ACC_INIT);
          idx_d   = IW'(EXP_BITS - 1);
          state_d = CHECK;
        end
      end
      CHECK: begin
        phase_d = PH_SQ;
        if (mod_q == '0) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else if (mod_q == SIZE'(1)) begin
          res_d   = '0;
          err_d   = 1'b0;
          state_d = DONE;
        end else begin
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
          if (msb_zero) begin
            res_d   = SIZE'(ACC_INIT);
            err_d   = 1'b0;
            state_d = DONE;
          end else begin
            idx_d   = msb_idx;
            state_d = ISSUE;
          end
`else
          state_d = ISSUE;
`endif
        end
      end
      ISSUE: begin
        if (mm_in_tready) state_d = WAIT;
      end
      WAIT: begin
        if (mm_out_tvalid) begin
          acc_d   = mm_out_tdata;
          state_d = RECYCLE;
        end
      end
      RECYCLE: begin
        if (phase_q == PH_SQ && exp_q[idx_q]) begin
          phase_d = PH_MUL;
          state_d = ISSUE;
        end else begin
          state_d = ADVANCE;
        end
      end
      ADVANCE: begin
        if (idx_q == '0) begin
          res_d   = acc_q;
          err_d   = 1'b0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q - IW'(1);
          phase_d = PH_SQ;
          state_d = ISSUE;
        end
      end
      DONE: begin
        if (out_tready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= PH_SQ;
      acc_q   <= SIZE'(ACC_INIT);
      idx_q   <= IW'(EXP_BITS - 1);
      base_q  <= '0;
      exp_q   <= '0;
      mod_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      exp_q   <= exp_d;
      mod_q   <= mod_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // Unit is single-shot: recycle it for one cycle after each product.
  assign mm_rst                = rst | (state_q == RECYCLE);
  assign in_tready             = (state_q == IDLE);
  assign busy                  = (state_q != IDLE);
  assign out_tvalid            = (state_q == DONE);
  assign out_tdata             = res_q;
  assign out_err               = err_q;
  assign mm_in_tvalid          = (state_q == ISSUE);
  assign mm_out_tready         = (state_q == WAIT);
  assign mm_multiplier_tdata   = acc_q;
  assign mm_multiplicand_tdata = (phase_q == PH_MUL) ? base_q : acc_q;
  assign mm_modulus_tdata      = mod_q;

endmodule

// File: tb/tb_mod_exp_controller.sv
// Bench for mod_exp_controller: behavioural single-shot multiply-mod
// unit plus a scoreboard of reference exponentiation results.
module tb_mod_exp_controller;

  localparam int SIZE     = 64;
  localparam int EXP_BITS = 64;

  logic                clk = 1'b0;
  logic                rst;
  logic [SIZE-1:0]     in_base_tdata;
  logic [EXP_BITS-1:0] in_exp_tdata;
  logic [SIZE-1:0]     in_mod_tdata;
  logic                in_tvalid;
  logic                in_tready;
  logic [SIZE-1:0]     out_tdata;
  logic                out_err;
  logic                out_tvalid;
  logic                out_tready;
  logic                mm_rst;
  logic [SIZE-1:0]     mm_multiplier_tdata;
  logic [SIZE-1:0]     mm_multiplicand_tdata;
  logic [SIZE-1:0]     mm_modulus_tdata;
  logic                mm_in_tvalid;
  logic                mm_in_tready;
  logic [SIZE-1:0]     mm_out_tdata;
  logic                mm_out_tvalid;
  logic                mm_out_tready;
  logic                busy;

  mod_exp_controller #(
    .SIZE    (SIZE),
    .EXP_BITS(EXP_BITS)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .in_base_tdata        (in_base_tdata),
    .in_exp_tdata         (in_exp_tdata),
    .in_mod_tdata         (in_mod_tdata),
    .in_tvalid            (in_tvalid),
    .in_tready            (in_tready),
    .out_tdata            (out_tdata),
    .out_err              (out_err),
    .out_tvalid           (out_tvalid),
    .out_tready           (out_tready),
    .mm_rst               (mm_rst),
    .mm_multiplier_tdata  (mm_multiplier_tdata),
    .mm_multiplicand_tdata(mm_multiplicand_tdata),
    .mm_modulus_tdata     (mm_modulus_tdata),
    .mm_in_tvalid         (mm_in_tvalid),
    .mm_in_tready         (mm_in_tready),
    .mm_out_tdata         (mm_out_tdata),
    .mm_out_tvalid        (mm_out_tvalid),
    .mm_out_tready        (mm_out_tready),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int hs_count    = 0;
  int rst_pulses  = 0;
  int unstable    = 0;
  int proto_err   = 0;
  int last_tx     = 0;
  bit stall       = 1'b0;

  logic [64:0] sb[$];

  // Behavioural multiply-mod unit: accepts one product per reset.
  int              u_st  = 0;
  int              u_cnt = 0;
  logic [SIZE-1:0] u_res = '0;
  logic            rdy_r = 1'b1;
  logic            pend  = 1'b0;
  logic [SIZE-1:0] pa, pb, pm;

  assign mm_in_tready  = (u_st == 0) && rdy_r;
  assign mm_out_tvalid = (u_st == 2);
  assign mm_out_tdata  = u_res;

  function automatic logic [63:0] mulmod(input logic [63:0] a, b, m);
    logic [127:0] p;
    p = {64'd0, a} * {64'd0, b};
    p = p % {64'd0, m};
    return p[63:0];
  endfunction

  always @(posedge clk) begin
    rdy_r <= stall ? ($urandom_range(0, 1) == 1) : 1'b1;
    if (mm_rst && !rst) rst_pulses <= rst_pulses + 1;
    if (u_st == 3 && mm_in_tvalid) proto_err <= proto_err + 1;
    if (pend && mm_in_tvalid &&
        ({pa, pb, pm} !== {mm_multiplier_tdata, mm_multiplicand_tdata,
                           mm_modulus_tdata}))
      unstable <= unstable + 1;
    pend <= mm_in_tvalid && !mm_in_tready;
    pa   <= mm_multiplier_tdata;
    pb   <= mm_multiplicand_tdata;
    pm   <= mm_modulus_tdata;
    if (mm_rst) begin
      u_st <= 0;
    end else begin
      case (u_st)
        0: if (mm_in_tvalid && mm_in_tready) begin
          hs_count <= hs_count + 1;
          u_res    <= mulmod(mm_multiplier_tdata, mm_multiplicand_tdata,
                             mm_modulus_tdata);
          u_cnt    <= stall ? $urandom_range(0, 3) : 0;
          u_st     <= 1;
        end
        1: if (u_cnt == 0) u_st <= 2;
           else u_cnt <= u_cnt - 1;
        2: if (mm_out_tready) u_st <= 3;
        default: ;
      endcase
    end
  end

  // Right-to-left reference, independent of the DUT's scan order.
  function automatic logic [63:0] ref_exp(input logic [63:0] b, e, m);
    logic [127:0] r, x, mm;
    if (m == 64'd0 || m == 64'd1) return 64'd0;
    mm = {64'd0, m};
    r  = 128'd1;
    x  = {64'd0, b} % mm;
    for (int i = 0; i < 64; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return r[63:0];
  endfunction

  function automatic int exp_tx(input logic [63:0] e, m);
    int pc;
    int top;
    pc  = 0;
    top = -1;
    if (m == 64'd0 || m == 64'd1) return 0;
    for (int i = 0; i < 64; i++) begin
      if (e[i]) begin
        pc++;
        top = i;
      end
    end
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
    return (top < 0) ? 0 : top + 1 + pc;
`else
    return 64 + pc;
`endif
  endfunction

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic run_op(input logic [63:0] b, e, m, input bit st);
    int          hs0, rp0, un0, pe0, n;
    bit          ok, hs, chg;
    logic [63:0] d0;
    logic        e0;
    logic [64:0] expv;
    hs0 = hs_count;
    rp0 = rst_pulses;
    un0 = unstable;
    pe0 = proto_err;
    stall = st;
    in_base_tdata = b;
    in_exp_tdata  = e;
    in_mod_tdata  = m;
    in_tvalid     = 1'b1;
    n = 0;
    do begin
      ok = in_tready;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 100);
    in_tvalid = 1'b0;
    check("in_accept", 128'(ok), 128'(1));
    sb.push_back({(m == 64'd0), ref_exp(b, e, m)});
    n = 0;
    while (!out_tvalid && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    check("out_timeout", 128'(out_tvalid), 128'(1));
    if (!out_tvalid) return;
    check("busy_done", 128'(busy), 128'(1));
    d0  = out_tdata;
    e0  = out_err;
    chg = 1'b0;
    do begin
      out_tready = st ? ($urandom_range(0, 2) == 0) : 1'b1;
      hs = out_tready;
      if (out_tdata !== d0 || out_err !== e0 || !out_tvalid) chg = 1'b1;
      @(posedge clk); #1;
    end while (!hs);
    out_tready = 1'b0;
    check("out_stable", 128'(chg), 128'(0));
    check("idle_in_tready", 128'(in_tready), 128'(1));
    check("no_valid_after", 128'(out_tvalid), 128'(0));
    if (sb.size() == 0) begin
      check("sb_nonempty", 128'(0), 128'(1));
    end else begin
      expv = sb.pop_front();
      check("result", 128'({e0, d0}), 128'(expv));
    end
    last_tx = hs_count - hs0;
    check("tx_count", 128'(last_tx), 128'(exp_tx(e, m)));
    check("recycle_pulses", 128'(rst_pulses - rp0), 128'(last_tx));
    check("operand_stable", 128'(unstable - un0), 128'(0));
    check("single_shot", 128'(proto_err - pe0), 128'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  seen;
    rst           = 1'b1;
    in_tvalid     = 1'b0;
    in_base_tdata = '0;
    in_exp_tdata  = '0;
    in_mod_tdata  = '0;
    out_tready    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_tready", 128'(in_tready), 128'(1));
    check("rst_out_tvalid", 128'(out_tvalid), 128'(0));
    check("rst_out_err", 128'(out_err), 128'(0));
    check("rst_out_tdata", 128'(out_tdata), 128'(0));
    check("rst_mm_in_tvalid", 128'(mm_in_tvalid), 128'(0));
    check("rst_mm_out_tready", 128'(mm_out_tready), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_mm_rst", 128'(mm_rst), 128'(1));
    rst = 1'b0;
    @(posedge clk); #1;
    check("mm_rst_released", 128'(mm_rst), 128'(0));

    run_op(64'd4, 64'd13, 64'd497, 1'b0);
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
    check("t1_tx_const", 128'(last_tx), 128'(7));
`else
    check("t1_tx_const", 128'(last_tx), 128'(67));
`endif
    run_op(64'd7, 64'd0, 64'd13, 1'b0);
    run_op(64'd5, 64'd3, 64'd0, 1'b0);
    run_op(64'd5, 64'd3, 64'd1, 1'b0);
    run_op(64'd600, 64'd1, 64'd497, 1'b0);
    run_op(64'd3, 64'd200, 64'd1000003, 1'b1);
    run_op(64'd123456789, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFC5, 1'b0);

    stall         = 1'b1;
    in_base_tdata = 64'd9;
    in_exp_tdata  = 64'd77;
    in_mod_tdata  = 64'd101;
    in_tvalid     = 1'b1;
    @(posedge clk); #1;
    in_tvalid = 1'b0;
    sb.push_back({1'b0, ref_exp(64'd9, 64'd77, 64'd101)});
    n = 0;
    while (!mm_out_tready && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_wait", 128'(mm_out_tready), 128'(1));
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    check("abort_mm_rst", 128'(mm_rst), 128'(1));
    rst = 1'b0;
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_in_tready", 128'(in_tready), 128'(1));
    check("abort_out_tvalid", 128'(out_tvalid), 128'(0));
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_tvalid) seen = 1'b1;
    end
    check("abort_no_stale", 128'(seen), 128'(0));
    run_op(64'd2, 64'd10, 64'd1000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
